// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and defaults shared by the uart_tx / uart_rx pair.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 217;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte holding register handshake plus the status pulses
// that the downstream frame parser consumes.
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] o_rx_byte;
  logic                      o_rx_valid;
  logic                      i_rx_ready;
  logic                      o_rx_active;
  logic                      o_frame_err;
  logic                      o_overrun;

  modport master (
    output o_rx_byte, o_rx_valid, o_rx_active, o_frame_err, o_overrun,
    input  i_rx_ready
  );

  modport slave (
    input  o_rx_byte, o_rx_valid, o_rx_active, o_frame_err, o_overrun,
    output i_rx_ready
  );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous serial line.
// Resets to the idle (high) level so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_async,
  output logic o_sync
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
    end
  end

  assign o_sync = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling and a valid/ready holding register.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around the sample point.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic      i_Clk,
  input  logic      i_Rst_n,
  input  logic      i_rx_serial,
  uart_rx_if.master rx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam int H  = (CLKS_PER_BIT - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int START_LAST = H;
`else
  localparam int START_LAST = H - 1;
`endif
  localparam logic [CW-1:0] START_END = CW'(START_LAST);
  localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);

  logic                      s_rx;
  logic                      bit_d;
  uart_state_e               state_q;
  logic [CW-1:0]             count_q;
  logic [BW-1:0]             bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] byte_q;
  logic                      valid_q;
  logic                      active_q;
  logic                      frame_err_q;
  logic                      overrun_q;

  uart_rx_sync u_sync (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_async (i_rx_serial),
    .o_sync  (s_rx)
  );

`ifdef UART_RX_MAJORITY_EN
  // The vote is taken one cycle late so the sample after P is available.
  logic [1:0] hist_q;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) hist_q <= 2'b11;
    else          hist_q <= {hist_q[0], s_rx};
  end

  assign bit_d = (hist_q[1] & hist_q[0]) | (hist_q[1] & s_rx) | (hist_q[0] & s_rx);
`else
  assign bit_d = s_rx;
`endif

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (valid_q && rx.i_rx_ready) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!s_rx) begin
            state_q  <= START;
            count_q  <= '0;
            active_q <= 1'b1;
          end
        end
        START: begin
          if (count_q == START_END) begin
            count_q <= '0;
            bit_q   <= '0;
            if (bit_d) begin
              state_q  <= IDLE;
              active_q <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        DATA: begin
          if (count_q == BIT_END) begin
            count_q <= '0;
            shift_q <= {bit_d, shift_q[UART_DATA_BITS-1:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == LAST_BIT) state_q <= STOP;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        STOP: begin
          if (count_q == BIT_END) begin
            count_q  <= '0;
            state_q  <= IDLE;
            active_q <= 1'b0;
            // A good byte loads only if the slot is free or being emptied this cycle.
            if (!bit_d) begin
              frame_err_q <= 1'b1;
            end else if (!valid_q || rx.i_rx_ready) begin
              byte_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx.o_rx_byte   = byte_q;
  assign rx.o_rx_valid  = valid_q;
  assign rx.o_rx_active = active_q;
  assign rx.o_frame_err = frame_err_q;
  assign rx.o_overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx at CLKS_PER_BIT=8.
// Follows UART_RX_MAJORITY_EN for decision latency and sample-point spike frames.
module tb_uart_rx;
  localparam int C = 8;
  localparam int H = (C - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int EXTRA = 1;
  localparam bit SPIKE = 1'b1;
`else
  localparam int EXTRA = 0;
  localparam bit SPIKE = 1'b0;
`endif
  // Pin edge to decision: 2 sync flops, 1 IDLE detect cycle, then H+9C (+1 vote).
  localparam int LAT = 3 + H + 9 * C + EXTRA;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic serial = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   passed = 0;

  uart_rx_if ifc ();

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_rx_serial (serial),
    .rx          (ifc.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got no finish, wanted finish");
    $fatal(1, "[TB] watchdog");
  end

  // Monitor: observed bytes, pulse counts and event cycles.
  logic [7:0] got_q[$];
  int fe_cnt, ov_cnt, fe_cyc, ov_cyc, vrise, vrun, valid_len, act_rise, act_fall;
  bit valid_prev, act_prev, active_seen;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.o_rx_valid && !valid_prev) begin
        got_q.push_back(ifc.o_rx_byte);
        vrise = cyc;
        vrun  = 0;
      end
      if (ifc.o_rx_valid) begin
        vrun++;
        valid_len = vrun;
      end
      if (ifc.o_frame_err) begin fe_cnt++; fe_cyc = cyc; end
      if (ifc.o_overrun)   begin ov_cnt++; ov_cyc = cyc; end
      if (ifc.o_rx_active && !act_prev) begin act_rise = cyc; active_seen = 1'b1; end
      if (!ifc.o_rx_active && act_prev) act_fall = cyc;
    end
    valid_prev = ifc.o_rx_valid;
    act_prev   = ifc.o_rx_active;
  end

  // Reference model: frame-level holding-register rules.
  logic [7:0] exp_q[$];
  int         exp_fe, exp_ov;
  logic       m_valid;
  logic [7:0] m_byte;

  task automatic model_frame(input logic [7:0] b, input bit good, input bit rdy);
    if (!good)                exp_fe++;
    else if (m_valid && !rdy) exp_ov++;
    else begin
      exp_q.push_back(b);
      m_byte  = b;
      m_valid = !rdy;
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    fe_cnt = 0; ov_cnt = 0; exp_fe = 0; exp_ov = 0;
    active_seen = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    if (n > 0) repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input bit spike);
    serial = v;
    if (spike) begin
      tick(H);
      serial = ~v;
      tick(1);
      serial = v;
      tick(C - H - 1);
    end else begin
      tick(C);
    end
  endtask

  // A bad stop is held low through its sample point, then released early.
  task automatic send_frame(input logic [7:0] b, input bit good, input bit spike);
    drive_bit(1'b0, spike);
    for (int i = 0; i < 8; i++) drive_bit(b[i], spike);
    if (good) begin
      drive_bit(1'b1, spike);
    end else begin
      serial = 1'b0;
      tick(C - 2);
      serial = 1'b1;
      tick(2);
    end
    serial = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; serial = 1'b1; ifc.i_rx_ready = 1'b1;
    tick(4);
    @(negedge clk);
    checks++; if (ifc.o_rx_byte !== 8'h00) $display("[TB] FAIL reset_byte got %h want 00", ifc.o_rx_byte); else passed++;
    checks++; if (ifc.o_rx_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", ifc.o_rx_valid); else passed++;
    checks++; if (ifc.o_rx_active !== 1'b0) $display("[TB] FAIL reset_active got %b want 0", ifc.o_rx_active); else passed++;
    checks++; if (ifc.o_frame_err !== 1'b0) $display("[TB] FAIL reset_ferr got %b want 0", ifc.o_frame_err); else passed++;
    checks++; if (ifc.o_overrun !== 1'b0) $display("[TB] FAIL reset_ovr got %b want 0", ifc.o_overrun); else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    int t0;
    clear_mon();
    t0 = cyc;
    model_frame(8'hA5, 1'b1, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(C);
    checks++; if (got_q.size() !== 1) $display("[TB] FAIL basic_count got %0d want 1", got_q.size()); else passed++;
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== exp_q[0]) $display("[TB] FAIL basic_byte got %h want %h", got_q[0], exp_q[0]); else passed++;
    end
    checks++; if (vrise !== t0 + LAT) $display("[TB] FAIL basic_valid_cycle got %0d want %0d", vrise, t0 + LAT); else passed++;
    checks++; if (valid_len !== 1) $display("[TB] FAIL basic_valid_len got %0d want 1", valid_len); else passed++;
    checks++; if (fe_cnt !== exp_fe) $display("[TB] FAIL basic_ferr got %0d want %0d", fe_cnt, exp_fe); else passed++;
    checks++; if (act_rise !== t0 + 3) $display("[TB] FAIL basic_active_rise got %0d want %0d", act_rise, t0 + 3); else passed++;
    checks++; if (act_fall !== t0 + LAT) $display("[TB] FAIL basic_active_fall got %0d want %0d", act_fall, t0 + LAT); else passed++;
  endtask

  task automatic test_glitch();
    int t0;
    clear_mon();
    t0 = cyc;
    serial = 1'b0;
    tick(2);
    serial = 1'b1;
    tick(3 * C);
    checks++; if (active_seen !== 1'b1) $display("[TB] FAIL glitch_active_seen got %b want 1", active_seen); else passed++;
    checks++; if (act_fall !== t0 + 3 + H + EXTRA) $display("[TB] FAIL glitch_active_fall got %0d want %0d", act_fall, t0 + 3 + H + EXTRA); else passed++;
    checks++; if (got_q.size() !== 0) $display("[TB] FAIL glitch_valid got %0d bytes want 0", got_q.size()); else passed++;
    checks++; if (fe_cnt !== 0) $display("[TB] FAIL glitch_ferr got %0d want 0", fe_cnt); else passed++;
  endtask

  task automatic test_framing();
    int t0;
    clear_mon();
    t0 = cyc;
    model_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(2 * C);
    checks++; if (fe_cnt !== exp_fe) $display("[TB] FAIL frame_err_count got %0d want %0d", fe_cnt, exp_fe); else passed++;
    checks++; if (fe_cyc !== t0 + LAT) $display("[TB] FAIL frame_err_cycle got %0d want %0d", fe_cyc, t0 + LAT); else passed++;
    checks++; if (got_q.size() !== 0) $display("[TB] FAIL frame_err_valid got %0d bytes want 0", got_q.size()); else passed++;
    model_frame(8'h81, 1'b1, 1'b1);
    send_frame(8'h81, 1'b1, 1'b0);
    tick(2 * C);
    checks++; if (got_q.size() !== exp_q.size()) $display("[TB] FAIL frame_next_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL frame_next_byte got %h want %h", got_q[i], exp_q[i]); else passed++;
    end
    checks++; if (fe_cnt !== exp_fe) $display("[TB] FAIL frame_next_ferr got %0d want %0d", fe_cnt, exp_fe); else passed++;
  endtask

  task automatic test_overrun();
    int t1;
    clear_mon();
    ifc.i_rx_ready = 1'b0;
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    t1 = cyc;
    model_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(2 * C);
    checks++; if (got_q.size() !== exp_q.size()) $display("[TB] FAIL ovr_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    checks++; if (ifc.o_rx_byte !== m_byte) $display("[TB] FAIL ovr_held_byte got %h want %h", ifc.o_rx_byte, m_byte); else passed++;
    checks++; if (ifc.o_rx_valid !== m_valid) $display("[TB] FAIL ovr_valid got %b want %b", ifc.o_rx_valid, m_valid); else passed++;
    checks++; if (ov_cnt !== exp_ov) $display("[TB] FAIL ovr_pulses got %0d want %0d", ov_cnt, exp_ov); else passed++;
    checks++; if (ov_cyc !== t1 + LAT) $display("[TB] FAIL ovr_cycle got %0d want %0d", ov_cyc, t1 + LAT); else passed++;
    ifc.i_rx_ready = 1'b1;
    tick(1);
    ifc.i_rx_ready = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
    checks++; if (ifc.o_rx_valid !== m_valid) $display("[TB] FAIL ovr_accept_valid got %b want %b", ifc.o_rx_valid, m_valid); else passed++;
    checks++; if (ifc.o_rx_byte !== 8'h11) $display("[TB] FAIL ovr_accept_byte got %h want 11", ifc.o_rx_byte); else passed++;
    @(posedge clk); #1 ifc.i_rx_ready = 1'b1;
    tick(2);
  endtask

  task automatic test_back_to_back();
    logic [7:0] frames [3];
    frames[0] = 8'h00; frames[1] = 8'hFF; frames[2] = 8'h55;
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      model_frame(frames[i], 1'b1, 1'b1);
      send_frame(frames[i], 1'b1, SPIKE);
    end
    tick(2 * C);
    checks++; if (got_q.size() !== exp_q.size()) $display("[TB] FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL b2b_byte%0d got %h want %h", i, got_q[i], exp_q[i]); else passed++;
    end
    checks++; if (fe_cnt !== 0) $display("[TB] FAIL b2b_ferr got %0d want 0", fe_cnt); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] b;
    clear_mon();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      model_frame(b, 1'b1, 1'b1);
      send_frame(b, 1'b1, 1'b0);
      tick(int'($urandom_range(0, 2 * C)));
    end
    tick(2 * C);
    checks++; if (got_q.size() !== exp_q.size()) $display("[TB] FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL rand_byte%0d got %h want %h", i, got_q[i], exp_q[i]); else passed++;
    end
    checks++; if (fe_cnt + ov_cnt !== 0) $display("[TB] FAIL rand_flags got %0d want 0", fe_cnt + ov_cnt); else passed++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] junk;
    junk = 8'hC3;
    clear_mon();
    ifc.i_rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0);
    tick(C);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(junk[i], 1'b0);
    serial = junk[4];
    tick(H);
    rst_n = 1'b0;
    tick(2);
    @(negedge clk);
    checks++; if (ifc.o_rx_byte !== 8'h00) $display("[TB] FAIL midrst_byte got %h want 00", ifc.o_rx_byte); else passed++;
    checks++; if (ifc.o_rx_valid !== 1'b0) $display("[TB] FAIL midrst_valid got %b want 0", ifc.o_rx_valid); else passed++;
    checks++; if (ifc.o_rx_active !== 1'b0) $display("[TB] FAIL midrst_active got %b want 0", ifc.o_rx_active); else passed++;
    checks++; if (ifc.o_frame_err !== 1'b0) $display("[TB] FAIL midrst_ferr got %b want 0", ifc.o_frame_err); else passed++;
    checks++; if (ifc.o_overrun !== 1'b0) $display("[TB] FAIL midrst_ovr got %b want 0", ifc.o_overrun); else passed++;
    @(posedge clk);
    #1;
    serial = 1'b1;
    rst_n = 1'b1;
    ifc.i_rx_ready = 1'b1;
    clear_mon();
    tick(2 * C);
    model_frame(8'h7E, 1'b1, 1'b1);
    send_frame(8'h7E, 1'b1, 1'b0);
    tick(2 * C);
    checks++; if (got_q.size() !== exp_q.size()) $display("[TB] FAIL midrst_next_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL midrst_next_byte got %h want %h", got_q[i], exp_q[i]); else passed++;
    end
    checks++; if (fe_cnt + ov_cnt !== 0) $display("[TB] FAIL midrst_flags got %0d want 0", fe_cnt + ov_cnt); else passed++;
  endtask

  initial begin
    ifc.i_rx_ready = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver, the companion to the continuous-mode `uart_tx` on the attitude-indicator serial link. It resynchronises the asynchronous serial line and detects start bits, rejecting false starts. Each bit is sampled at mid-bit, and every received byte is presented on a valid/ready holding register. Framing and overrun errors are flagged as single-cycle pulses for the downstream frame parser.

## Interface
- `CLKS_PER_BIT`, 217: clock cycles per bit. Must be ≥ 8. Counter width is `$clog2(CLKS_PER_BIT)`.
- `i_Clk`  in  1  system clock; all logic is on its rising edge.
- `i_Rst_n`  in  1  synchronous reset, active low.
- `i_rx_serial`  in  1  asynchronous serial line; idles high.
- `i_rx_ready`  in  1  consumer accepts the held byte when high together with `o_rx_valid`.
- `o_rx_byte`  out  8  received byte, LSB first on the wire. Stable while `o_rx_valid` is high.
- `o_rx_valid`  out  1  held byte available.
- `o_rx_active`  out  1  high in every state except IDLE.
- `o_frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `o_overrun`  out  1  one-cycle pulse when a completed byte is dropped.

## Operation
- **Reset** (`i_Rst_n`=0 at a clock edge):
  - state goes to IDLE; counters clear;
  - synchroniser flops go to 1;
  - `o_rx_byte`=0, and `o_rx_valid`, `o_rx_active`, `o_frame_err`, `o_overrun` all go to 0.
  - Reset mid-frame abandons the frame with no flags raised.
  - Reset takes priority over all other behaviour.
- **Synchroniser:** two flops. `s_rx` is the second flop output, and it is the only form of the line that the FSM sees.
- **Mid-bit offset:** H = (CLKS_PER_BIT-1)/2, integer division.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** on the first cycle with `s_rx`=0, go to START with count=0.
  - **START:** count up. At the sample point, if the sampled value is 1, it is a false start: return to IDLE with no flag. Otherwise, restart the count and go to DATA.
  - **DATA:** sample at each bit's sample point, shifting LSB-first into the shift register. After bit 7, go to STOP.
  - **STOP:** take a sample at the sample point.
    - Sampled 1: a good byte. Deliver it (see the holding register below).
    - Sampled 0: pulse `o_frame_err`; the byte is discarded.
    - Either way, return to IDLE the next cycle. No wait for the line to go high, so a low line immediately re-arms START.
- **Sample points** are counted from cycle 0, the IDLE cycle in which `s_rx`=0 is first seen:
  - start bit: cycle H;
  - data bit k: cycle H+(k+1)·CLKS_PER_BIT;
  - stop bit: cycle H+9·CLKS_PER_BIT.
- **Holding register:**
  - `o_rx_valid`&&`i_rx_ready` in a cycle clears valid on the next cycle.
  - A good byte completing while valid is 0, or in the same cycle as an acceptance, loads `o_rx_byte` and sets valid. No overrun is flagged.
  - A good byte completing while valid=1 and `i_rx_ready`=0 is dropped and `o_overrun` pulses. The held byte is unchanged.

## Timing
- Sync latency: 2 cycles from pin to `s_rx`.
- Decision latency:
  - `o_rx_valid`, `o_frame_err` and `o_overrun` rise at cycle H+9·C+1, where C = CLKS_PER_BIT.
  - With `UART_RX_MAJORITY_EN` defined they rise at cycle H+9·C+2.
- `o_rx_active` rises at cycle 1 and falls on the cycle the FSM re-enters IDLE.
- Back-to-back frames from `uart_tx` (start bit immediately after stop) are received without loss.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - each bit decision is the 2-of-3 majority of the values of `s_rx` at cycles P-1, P and P+1, where P is the sample point;
  - the decision and the next state are taken at P+1;
  - bit-period counting remains anchored to P;
  - the false-start check uses the majority.
- Not defined: single sample of `s_rx` at P; the decision is taken at P.

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE/START/DATA/STOP);
  - `UART_DATA_BITS`=8;
  - default `CLKS_PER_BIT`=217.
  - The package is shared with `uart_tx`.
- Sub-module `uart_rx_sync`: the two-flop synchroniser. It resets to 1 and has one instance.
- Majority voter is inline logic behind the `ifdef`.

## Test plan
All scenarios run at CLKS_PER_BIT=8 (H=3) with `i_rx_ready`=1 unless stated.
- Byte 0xA5 framed 8N1 → `o_rx_byte`=0xA5, one cycle of valid, `o_frame_err`=0.
- Line low for 2 cycles then high (glitch) → FSM returns to IDLE, no valid, no error.
- Frame 0x3C with the stop bit driven low → `o_frame_err` pulses one cycle, valid stays 0; a following 0x81 is received correctly.
- `i_rx_ready`=0 while 0x11 then 0x22 arrive → `o_rx_byte` stays 0x11, `o_overrun` pulses at the end of the 0x22 frame. Then ready=1 for 1 cycle → valid clears.
- Drive back-to-back frames 0x00, 0xFF, 0x55 from `uart_tx` with no gap → all three are received in order. With majority enabled, a one-cycle spike at each sample point is rejected.
- Assert `i_Rst_n`=0 during data bit 4 → all outputs go to 0. The next full frame, 0x7E, is received correctly.
